// File: rtl/fpu_issue_pkg.sv
// Shared types, flag bit positions and opcode helper for the FPU issue controller.
package fpu_issue_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    I2F = 3'd4,
    F2I = 3'd5
  } fpu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int NUM_FLAGS     = 8;
  localparam int FLG_INE       = 0;
  localparam int FLG_OVERFLOW  = 1;
  localparam int FLG_UNDERFLOW = 2;
  localparam int FLG_DIV_ZERO  = 3;
  localparam int FLG_INF       = 4;
  localparam int FLG_ZERO      = 5;
  localparam int FLG_QNAN      = 6;
  localparam int FLG_SNAN      = 7;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= F2I);
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request, FPU operand/command and response signals of the issue controller.
// master = controller side, slave = upstream/FPU/downstream side.
interface fpu_issue_ctrl_if
  import fpu_issue_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [DATA_W-1:0]    req_opa;
  logic [DATA_W-1:0]    req_opb;
  logic [2:0]           req_op;
  logic [1:0]           req_rmode;

  logic [DATA_W-1:0]    fpu_opa;
  logic [DATA_W-1:0]    fpu_opb;
  logic [2:0]           fpu_op;
  logic [1:0]           fpu_rmode;
  logic                 fpu_start;
  logic [DATA_W-1:0]    fpu_result;
  logic                 ine, overflow, underflow, div_zero, inf, zero, qnan, snan;
  logic                 ready;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATA_W-1:0]    rsp_result;
  logic [NUM_FLAGS-1:0] rsp_flags;
  logic                 rsp_timeout;
  logic                 rsp_err;

  modport master (
    input  req_valid, req_opa, req_opb, req_op, req_rmode,
    output req_ready,
    output fpu_opa, fpu_opb, fpu_op, fpu_rmode, fpu_start,
    input  fpu_result, ine, overflow, underflow, div_zero, inf, zero, qnan, snan, ready,
    output rsp_valid, rsp_result, rsp_flags, rsp_timeout, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_opa, req_opb, req_op, req_rmode,
    input  req_ready,
    input  fpu_opa, fpu_opb, fpu_op, fpu_rmode, fpu_start,
    output fpu_result, ine, overflow, underflow, div_zero, inf, zero, qnan, snan, ready,
    input  rsp_valid, rsp_result, rsp_flags, rsp_timeout, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/fpu_issue_timer.sv
// Loadable up-counter with clear and enable; tc flags the last allowed WAIT cycle.
module fpu_issue_timer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (load) cnt_d = load_val;
    else if (en)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding FPU issue controller: request -> start pulse -> wait/timeout -> response.
// Optional FPU_ISSUE_STICKY_FLAGS_EN adds sticky_flags/sticky_clr accumulating response flags.
module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  fpu_issue_ctrl_if.master     bus
`ifdef FPU_ISSUE_STICKY_FLAGS_EN
  ,
  input  logic                 sticky_clr,
  output logic [NUM_FLAGS-1:0] sticky_flags
`endif
);

  state_e               state_q, state_d;
  logic                 req_ready_q, req_ready_d;
  logic [DATA_W-1:0]    fpu_opa_q, fpu_opa_d;
  logic [DATA_W-1:0]    fpu_opb_q, fpu_opb_d;
  logic [2:0]           fpu_op_q, fpu_op_d;
  logic [1:0]           fpu_rmode_q, fpu_rmode_d;
  logic                 fpu_start_q, fpu_start_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_result_q, rsp_result_d;
  logic [NUM_FLAGS-1:0] rsp_flags_q, rsp_flags_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [NUM_FLAGS-1:0] fpu_flags;
  logic                 tmr_tc;

  assign fpu_flags[FLG_INE]       = bus.ine;
  assign fpu_flags[FLG_OVERFLOW]  = bus.overflow;
  assign fpu_flags[FLG_UNDERFLOW] = bus.underflow;
  assign fpu_flags[FLG_DIV_ZERO]  = bus.div_zero;
  assign fpu_flags[FLG_INF]       = bus.inf;
  assign fpu_flags[FLG_ZERO]      = bus.zero;
  assign fpu_flags[FLG_QNAN]      = bus.qnan;
  assign fpu_flags[FLG_SNAN]      = bus.snan;

  // Counter runs only while waiting; any other state holds it at zero.
  fpu_issue_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q != WAIT),
    .en       ((state_q == WAIT) && !bus.ready),
    .load     (1'b0),
    .load_val ('0),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d       = state_q;
    fpu_opa_d     = fpu_opa_q;
    fpu_opb_d     = fpu_opb_q;
    fpu_op_d      = fpu_op_q;
    fpu_rmode_d   = fpu_rmode_q;
    fpu_start_d   = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_err_d     = rsp_err_q;
    case (state_q)
      IDLE: begin
        // req_ready_q is low for one cycle after reset, so gate acceptance on it.
        if (bus.req_valid && req_ready_q) begin
          fpu_opa_d   = bus.req_opa;
          fpu_opb_d   = bus.req_opb;
          fpu_op_d    = bus.req_op;
          fpu_rmode_d = bus.req_rmode;
          if (is_legal_op(bus.req_op)) begin
            state_d     = ISSUE;
            fpu_start_d = 1'b1;
          end else begin
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_result_d  = '0;
            rsp_flags_d   = '0;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.ready) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_result_d  = bus.fpu_result;
          rsp_flags_d   = fpu_flags;
          rsp_timeout_d = 1'b0;
          rsp_err_d     = 1'b0;
        end else if (tmr_tc) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_result_d  = '0;
          rsp_flags_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_err_d     = 1'b0;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_err_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      fpu_opa_q     <= '0;
      fpu_opb_q     <= '0;
      fpu_op_q      <= '0;
      fpu_rmode_q   <= '0;
      fpu_start_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      fpu_opa_q     <= fpu_opa_d;
      fpu_opb_q     <= fpu_opb_d;
      fpu_op_q      <= fpu_op_d;
      fpu_rmode_q   <= fpu_rmode_d;
      fpu_start_q   <= fpu_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.fpu_opa     = fpu_opa_q;
  assign bus.fpu_opb     = fpu_opb_q;
  assign bus.fpu_op      = fpu_op_q;
  assign bus.fpu_rmode   = fpu_rmode_q;
  assign bus.fpu_start   = fpu_start_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_flags   = rsp_flags_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.rsp_err     = rsp_err_q;

`ifdef FPU_ISSUE_STICKY_FLAGS_EN
  logic [NUM_FLAGS-1:0] sticky_q, sticky_d;

  // A same-cycle clear beats the OR of the response being handed over.
  always_comb begin
    sticky_d = sticky_q;
    if ((state_q == RESP) && bus.rsp_ready) sticky_d = sticky_q | rsp_flags_q;
    if (sticky_clr) sticky_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) sticky_q <= '0;
    else      sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed-vector bench for fpu_issue_ctrl with hand-computed expectations.
module tb_fpu_issue_ctrl;

  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  fpu_issue_ctrl_if #(.DATA_W(32)) bus ();

`ifdef FPU_ISSUE_STICKY_FLAGS_EN
  logic       sticky_clr;
  logic [7:0] sticky_flags;
  fpu_issue_ctrl #(.DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sticky_clr(sticky_clr), .sticky_flags(sticky_flags));
`else
  fpu_issue_ctrl #(.DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [7:0] f);
    bus.ine = f[0]; bus.overflow = f[1]; bus.underflow = f[2]; bus.div_zero = f[3];
    bus.inf = f[4]; bus.zero = f[5]; bus.qnan = f[6]; bus.snan = f[7];
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [1:0] rm);
    int w;
    w = 0;
    while (!bus.req_ready && w < 20) begin tick(); w++; end
    chk("req_ready_before_issue", 64'(bus.req_ready), 64'(1));
    bus.req_valid = 1'b1; bus.req_opa = a; bus.req_opb = b; bus.req_op = op; bus.req_rmode = rm;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Called in the start cycle; raises ready lat cycles later.
  task automatic reply(input int lat, input logic [31:0] res, input logic [7:0] f);
    int starts;
    bit early;
    starts = 0; early = 1'b0;
    for (int i = 0; i < lat; i++) begin
      tick();
      if (bus.fpu_start) starts++;
      if (bus.rsp_valid) early = 1'b1;
    end
    chk("extra_start_pulses", 64'(starts), 64'(0));
    chk("rsp_before_ready", 64'(early), 64'(0));
    bus.ready = 1'b1; bus.fpu_result = res; set_flags(f);
    tick();
    bus.ready = 1'b0; bus.fpu_result = '0; set_flags(8'h00);
    chk("rsp_valid_after_ready", 64'(bus.rsp_valid), 64'(1));
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    tick();
    chk("rsp_valid_drop", 64'(bus.rsp_valid), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  bad;
    bit  st;
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_opa = '0; bus.req_opb = '0; bus.req_op = '0; bus.req_rmode = '0;
    bus.fpu_result = '0; bus.ready = 1'b0; bus.rsp_ready = 1'b1; set_flags(8'h00);
`ifdef FPU_ISSUE_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    tick(); tick();
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_fpu_start", 64'(bus.fpu_start), 64'(0));
    chk("rst_rsp_err",   64'(bus.rsp_err), 64'(0));
    rst = 1'b1;
    tick();
    chk("idle_req_ready", 64'(bus.req_ready), 64'(1));

    // add: 1.0 + 2.0 = 3.0, ready 7 cycles after start
    issue(32'h3F800000, 32'h40000000, 3'd0, 2'd1);
    chk("add_start", 64'(bus.fpu_start), 64'(1));
    chk("add_opa", 64'(bus.fpu_opa), 64'h3F800000);
    chk("add_opb", 64'(bus.fpu_opb), 64'h40000000);
    chk("add_rmode", 64'(bus.fpu_rmode), 64'(1));
    chk("add_busy_ready", 64'(bus.req_ready), 64'(0));
    reply(7, 32'h40400000, 8'h00);
    chk("add_result", 64'(bus.rsp_result), 64'h40400000);
    chk("add_flags", 64'(bus.rsp_flags), 64'h00);
    chk("add_timeout", 64'(bus.rsp_timeout), 64'(0));
    handshake();
    chk("add_back_idle", 64'(bus.req_ready), 64'(1));

    // divide by zero: div_zero and inf -> bits 3 and 4
    issue(32'h3F800000, 32'h00000000, 3'd3, 2'd0);
    chk("div_op", 64'(bus.fpu_op), 64'(3));
    reply(3, 32'h7F800000, 8'b0001_1000);
    chk("div_result", 64'(bus.rsp_result), 64'h7F800000);
    chk("div_flags", 64'(bus.rsp_flags), 64'h18);
    chk("div_timeout", 64'(bus.rsp_timeout), 64'(0));
    handshake();

    // flag packing: snan, underflow, ine
    issue(32'h1, 32'h2, 3'd2, 2'd2);
    reply(1, 32'h00000007, 8'b1000_0101);
    chk("mul_flags", 64'(bus.rsp_flags), 64'h85);
    handshake();

    // ready on the terminal-count cycle wins over timeout
    issue(32'h5, 32'h6, 3'd1, 2'd0);
    reply(TO, 32'h11111111, 8'h00);
    chk("tc_ready_timeout", 64'(bus.rsp_timeout), 64'(0));
    chk("tc_ready_result", 64'(bus.rsp_result), 64'h11111111);
    handshake();

    // timeout
    bus.rsp_ready = 1'b0;
    issue(32'h9, 32'h0, 3'd4, 2'd0);
    k = 0;
    while (!bus.rsp_valid && k < 200) begin tick(); k++; end
    chk("timeout_latency", 64'(k), 64'(TO + 1));
    chk("timeout_flag", 64'(bus.rsp_timeout), 64'(1));
    chk("timeout_result", 64'(bus.rsp_result), 64'h0);
    chk("timeout_flags", 64'(bus.rsp_flags), 64'h0);
    chk("timeout_err", 64'(bus.rsp_err), 64'(0));
    bus.ready = 1'b1; bus.fpu_result = 32'hDEADBEEF; set_flags(8'hFF);
    tick();
    bus.ready = 1'b0; bus.fpu_result = '0; set_flags(8'h00);
    chk("late_ready_result", 64'(bus.rsp_result), 64'h0);
    chk("late_ready_flags", 64'(bus.rsp_flags), 64'h0);
    chk("late_ready_timeout", 64'(bus.rsp_timeout), 64'(1));
    handshake();
    chk("timeout_clears", 64'(bus.rsp_timeout), 64'(0));
    bus.ready = 1'b1; tick(); bus.ready = 1'b0; tick();
    chk("idle_ready_ignored", 64'(bus.rsp_valid), 64'(0));

    // backpressure
    bus.rsp_ready = 1'b0;
    issue(32'h1, 32'h2, 3'd2, 2'd3);
    reply(2, 32'h12345678, 8'h01);
    bus.req_valid = 1'b1; bus.req_opa = 32'hAAAA0000; bus.req_opb = 32'h3; bus.req_op = 3'd0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!bus.rsp_valid || bus.rsp_result !== 32'h12345678 || bus.rsp_flags !== 8'h01 ||
          bus.req_ready || bus.fpu_start || bus.rsp_err || bus.rsp_timeout) bad = 1'b1;
    end
    chk("bp_stable", 64'(bad), 64'(0));
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_hs_no_accept", 64'(bus.fpu_start), 64'(0));
    chk("bp_hs_ready", 64'(bus.req_ready), 64'(1));
    tick();
    bus.req_valid = 1'b0;
    chk("bp_next_start", 64'(bus.fpu_start), 64'(1));
    chk("bp_next_opa", 64'(bus.fpu_opa), 64'hAAAA0000);
    reply(2, 32'h00000055, 8'h40);
    chk("bp_next_result", 64'(bus.rsp_result), 64'h55);
    handshake();

    // illegal opcode
    issue(32'h5, 32'h6, 3'd7, 2'd0);
    st = bus.fpu_start;
    k = 1;
    while (!bus.rsp_valid && k < 2) begin tick(); k++; st = st | bus.fpu_start; end
    chk("ill_valid", 64'(bus.rsp_valid), 64'(1));
    chk("ill_err", 64'(bus.rsp_err), 64'(1));
    chk("ill_timeout", 64'(bus.rsp_timeout), 64'(0));
    chk("ill_result", 64'(bus.rsp_result), 64'h0);
    chk("ill_flags", 64'(bus.rsp_flags), 64'h0);
    chk("ill_fpu_op", 64'(bus.fpu_op), 64'(7));
    handshake();
    st = st | bus.fpu_start;
    chk("ill_no_start", 64'(st), 64'(0));
    chk("ill_err_clears", 64'(bus.rsp_err), 64'(0));

    // reset during WAIT
    issue(32'hCAFEF00D, 32'h1, 3'd0, 2'd2);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("wrst_opa", 64'(bus.fpu_opa), 64'h0);
    chk("wrst_op_rmode", 64'({bus.fpu_op, bus.fpu_rmode}), 64'h0);
    chk("wrst_start", 64'(bus.fpu_start), 64'(0));
    chk("wrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("wrst_req_ready", 64'(bus.req_ready), 64'(0));
    rst = 1'b1;
    bus.ready = 1'b1; bus.fpu_result = 32'h00000ABC;
    tick();
    bus.ready = 1'b0; bus.fpu_result = '0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rsp_valid) bad = 1'b1;
    end
    chk("wrst_no_rsp", 64'(bad), 64'(0));
    chk("wrst_idle", 64'(bus.req_ready), 64'(1));
    issue(32'h7, 32'h8, 3'd5, 2'd0);
    reply(1, 32'h0000000F, 8'h20);
    chk("post_rst_result", 64'(bus.rsp_result), 64'h0F);
    chk("post_rst_flags", 64'(bus.rsp_flags), 64'h20);
    handshake();

`ifdef FPU_ISSUE_STICKY_FLAGS_EN
    chk("sticky_accum", 64'(sticky_flags), 64'h20);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky_clear", 64'(sticky_flags), 64'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
